rom_port_arbiter: RTL and testbench

Two-master arbiter for the data read port of the synchronous instruction/constant ROM. It accepts word reads from the CPU load/store unit (master 0) and a secondary requester such as the debug module or a DMA/checksum engine (master 1). Each cycle it grants at most one request and drives the ROM data port. One cycle later it routes the ROM's registered read data, or an error response, back to the granted master. It sits between the SoC data interconnect and the ROM; the ROM instruction port is not touched.

---
 rtl/rom_port_arbiter.sv | 92 +++++++++
 tb/tb_rom_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-master arbiter for the ROM data read port with a one-cycle registered response path.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to master 0.
module rom_port_arbiter #(
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          m0_req_i,
    input  logic [31:0]   m0_addr_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_rdata_o,
    output logic          m0_err_o,

    input  logic          m1_req_i,
    input  logic [31:0]   m1_addr_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_rdata_o,
    output logic          m1_err_o,

    output logic          rom_en_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [31:0]   rom_rdata_i
);

    logic        prefer_m1;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        addr_ok;

    logic        rsp_valid_q;
    logic        rsp_owner_q;
    logic        rsp_err_q;

`ifdef ROM_ARB_RR_EN
    logic ptr_q;

    // Pointer names the preferred master: the one not granted most recently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (any_gnt) begin
            ptr_q <= gnt0;
        end
    end

    assign prefer_m1 = ptr_q;
`else
    assign prefer_m1 = 1'b0;
`endif

    always_comb begin
        gnt0     = m0_req_i & (~m1_req_i | ~prefer_m1);
        gnt1     = m1_req_i & ~gnt0;
        any_gnt  = gnt0 | gnt1;
        sel_addr = gnt0 ? m0_addr_i : m1_addr_i;
        addr_ok  = (sel_addr[31:AW+2] == '0) && (sel_addr[1:0] == 2'b00);
    end

    assign m0_gnt_o   = gnt0;
    assign m1_gnt_o   = gnt1;
    assign rom_en_o   = any_gnt & addr_ok;
    assign rom_addr_o = rom_en_o ? sel_addr[AW+1:2] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= any_gnt;
            rsp_owner_q <= gnt1;
            rsp_err_q   <= any_gnt & ~addr_ok;
        end
    end

    // Read data is zeroed unless a non-error response is owned, so stale ROM output never leaks.
    always_comb begin
        m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
        m1_rvalid_o = rsp_valid_q & rsp_owner_q;
        m0_err_o    = m0_rvalid_o & rsp_err_q;
        m1_err_o    = m1_rvalid_o & rsp_err_q;
        m0_rdata_o  = (m0_rvalid_o && !rsp_err_q) ? rom_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o && !rsp_err_q) ? rom_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed cases plus randomized traffic against a
// behavioural model. Honours ROM_ARB_RR_EN in the model when the design is built with it.
module tb_rom_port_arbiter;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic          clk;
    logic          rst_ni;
    logic          m0_req, m1_req;
    logic [31:0]   m0_addr, m1_addr;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_q;

    logic [31:0] mem [MEM_DEPTH];

    int errors = 0;
    int checks = 0;

    // Model state: preferred master, and the response expected in the next cycle.
    bit          pref_m1;
    bit          exp_v, exp_owner, exp_err;
    logic [31:0] exp_data;
    logic        g0_seen, g1_seen;

    rom_port_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .m0_req_i    (m0_req),
        .m0_addr_i   (m0_addr),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m0_err_o    (m0_err),
        .m1_req_i    (m1_req),
        .m1_addr_i   (m1_addr),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .m1_err_o    (m1_err),
        .rom_en_o    (rom_en),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: output register updates only when enabled.
    always @(posedge clk) begin
        if (rom_en) rom_q <= mem[rom_addr];
    end

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pref_m1 = 1'b0;
        exp_v   = 1'b0;
        g0_seen = 1'b0;
        g1_seen = 1'b0;
    endtask

    // Compare every output with the model, then advance the model by one cycle.
    task automatic check_cycle();
        logic        w0, w1, ok;
        logic [31:0] a;
        chkb("m0_rvalid", m0_rvalid, exp_v && !exp_owner);
        chkb("m0_err", m0_err, exp_v && !exp_owner && exp_err);
        chkw("m0_rdata", m0_rdata, (exp_v && !exp_owner && !exp_err) ? exp_data : 32'h0);
        chkb("m1_rvalid", m1_rvalid, exp_v && exp_owner);
        chkb("m1_err", m1_err, exp_v && exp_owner && exp_err);
        chkw("m1_rdata", m1_rdata, (exp_v && exp_owner && !exp_err) ? exp_data : 32'h0);

        w0 = m0_req && (!m1_req || !pref_m1);
        w1 = m1_req && !w0;
        a  = w0 ? m0_addr : m1_addr;
        ok = (w0 || w1) && (a < 32'(MEM_DEPTH * 4)) && (a % 4 == 0);
        chkb("m0_gnt", m0_gnt, w0);
        chkb("m1_gnt", m1_gnt, w1);
        chkb("rom_en", rom_en, ok);
        chkw("rom_addr", 32'(rom_addr), ok ? a / 4 : 32'h0);

        exp_v     = w0 || w1;
        exp_owner = w1;
        exp_err   = !ok;
        exp_data  = ok ? mem[a / 4] : 32'h0;
`ifdef ROM_ARB_RR_EN
        if (w0 || w1) pref_m1 = w0;
`endif
        g0_seen = m0_gnt;
        g1_seen = m1_gnt;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, MEM_DEPTH - 1)) * 4;
        else if (r < 8) return 32'($urandom_range(0, MEM_DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else return (32'($urandom_range(1, 1000)) << 10) | (32'($urandom_range(0, 255)) << 2);
    endfunction

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
        rom_q   = 32'hDEAD_BEEF;
        rst_ni  = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        m0_addr = 32'h0;
        m1_addr = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chkb("rst_rom_en", rom_en, 1'b0);
        chkw("rst_rom_addr", 32'(rom_addr), 32'h0);
        chkb("rst_m0_rvalid", m0_rvalid, 1'b0);
        chkw("rst_m1_rdata", m1_rdata, 32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            #1 chkb("idle_en", rom_en, 1'b0);
            tick();
        end

        // Single read of byte 0x10 -> word 4
        m0_req = 1'b1; m0_addr = 32'h10;
        #2;
        chkb("single_gnt", m0_gnt, 1'b1);
        chkb("single_en", rom_en, 1'b1);
        chkw("single_addr", 32'(rom_addr), 32'd4);
        tick();
        m0_req = 1'b0;
        #2;
        chkb("single_rvalid", m0_rvalid, 1'b1);
        chkw("single_rdata", m0_rdata, mem[4]);
        tick();

        // Out-of-range on m1, misaligned on m0
        m1_req = 1'b1; m1_addr = 32'h400;
        #2 chkb("oor_en", rom_en, 1'b0);
        tick();
        m1_req = 1'b0;
        #2;
        chkb("oor_rvalid", m1_rvalid, 1'b1);
        chkb("oor_err", m1_err, 1'b1);
        chkw("oor_rdata", m1_rdata, 32'h0);
        tick();
        m0_req = 1'b1; m0_addr = 32'h2;
        #2 chkb("mis_en", rom_en, 1'b0);
        tick();
        m0_req = 1'b0;
        #2;
        chkb("mis_err", m0_err, 1'b1);
        chkw("mis_rdata", m0_rdata, 32'h0);
        tick();

        // Back-to-back reads of words 0, 1, 2
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                m0_req = 1'b1; m0_addr = 32'(i) * 4;
            end else begin
                m0_req = 1'b0;
            end
            #2;
            if (i > 0) begin
                chkb("b2b_rvalid", m0_rvalid, 1'b1);
                chkw("b2b_rdata", m0_rdata, mem[i - 1]);
            end
            tick();
        end

        // Grant in cycle N, then reset mid-way through the response cycle
        m0_req = 1'b1; m0_addr = 32'h8;
        tick();
        m0_req = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chkb("arst_rvalid", m0_rvalid, 1'b0);
        chkw("arst_rdata", m0_rdata, 32'h0);
        chkb("arst_en", rom_en, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        #1 chkb("post_rst_rvalid", m0_rvalid, 1'b0);
        tick();

        // Contention: both request for four cycles, then m0 drops
        m0_req = 1'b1; m0_addr = 32'h0;
        m1_req = 1'b1; m1_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ROM_ARB_RR_EN
            chkb("cont_m0_gnt", m0_gnt, (i % 2) == 0);
`else
            chkb("cont_m0_gnt", m0_gnt, 1'b1);
`endif
            tick();
        end
        m0_req = 1'b0;
        #1 chkb("cont_m1_gnt", m1_gnt, 1'b1);
        tick();
        m1_req = 1'b0;
        tick();

        // Randomized traffic; each master holds its request until granted
        for (int i = 0; i < 400; i++) begin
            if (!m0_req || g0_seen) begin
                m0_req  = ($urandom_range(0, 99) < 60);
                m0_addr = rand_addr();
            end
            if (!m1_req || g1_seen) begin
                m1_req  = ($urandom_range(0, 99) < 60);
                m1_addr = rand_addr();
            end
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
